// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_pkg : shared encodings for the IF/MEM byte-serial memory controller
// Revision     : 1.0
// ============================================================================
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MemIdle = 2'd0,
      MemXfer = 2'd1,
      MemDone = 2'd2
   } mem_state_e;

   typedef enum logic {
      OwnerIF  = 1'b0,
      OwnerMEM = 1'b1
   } owner_e;

   localparam logic [1:0] MemByte = 2'b00;
   localparam logic [1:0] MemHalf = 2'b01;
   localparam logic [1:0] MemWord = 2'b10;

   // Length code to byte count; the reserved code 11 behaves as a word.
   function automatic logic [2:0] len_bytes(input logic [1:0] code);
      case (code)
         MemByte: return 3'd1;
         MemHalf: return 3'd2;
         MemWord: return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : arbitrates IF and MEM onto one byte-wide RAM port, serialising
//            1/2/4-byte little-endian transfers and pulsing done per owner
// Revision : 1.0
// ============================================================================
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   input  logic                  if_flush_i,
   output logic                  if_done_o,
   output logic [31:0]           if_data_o,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_len_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   output logic                  mem_done_o,
   output logic [31:0]           mem_rdata_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [7:0]            ram_dout_o,
   output logic                  ram_wr_o,
   input  logic [7:0]            ram_din_i,
   output logic                  busy_o
);

   mem_state_e            r_state;
   mem_state_e            w_state_nxt;
   owner_e                r_owner;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_len;
   logic [31:0]           r_wdata;
   logic [2:0]            r_k;
   logic [31:0]           r_if_data;
   logic [31:0]           r_mem_rdata;

   logic                  w_grant_mem;
   logic                  w_grant_if;
   logic                  w_abort;
   logic [1:0]            w_lane;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [7:0]            w_ram_dout;
   logic                  w_ram_wr;
   logic                  w_if_done;
   logic                  w_mem_done;

   // Load data for the byte addressed last cycle lands in lane k-1.
   assign w_lane  = 2'(r_k - 3'd1);
   assign w_abort = if_flush_i && (r_owner == OwnerIF);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_mem = 1'b0;
      w_grant_if  = 1'b0;
      w_ram_addr  = '0;
      w_ram_dout  = 8'h00;
      w_ram_wr    = 1'b0;
      w_if_done   = 1'b0;
      w_mem_done  = 1'b0;
      case (r_state)
         MemIdle: begin
            if (mem_req_i) begin
               w_grant_mem = 1'b1;
               w_state_nxt = MemXfer;
            end else if (if_req_i && !if_flush_i) begin
               w_grant_if  = 1'b1;
               w_state_nxt = MemXfer;
            end
         end
         MemXfer: begin
            if (r_k < r_len) begin
               w_ram_addr = r_addr + {{(ADDR_WIDTH-3){1'b0}}, r_k};
            end
            if (r_we) begin
               w_ram_wr   = 1'b1;
               w_ram_dout = r_wdata[{r_k[1:0], 3'b000} +: 8];
               if (r_k == r_len - 3'd1) w_state_nxt = MemDone;
            end else if (r_k == r_len) begin
               w_state_nxt = MemDone;
            end
            if (w_abort) w_state_nxt = MemIdle;
         end
         MemDone: begin
            w_state_nxt = MemIdle;
            w_if_done   = (r_owner == OwnerIF) && !if_flush_i;
            w_mem_done  = (r_owner == OwnerMEM);
         end
         default: w_state_nxt = MemIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= MemIdle;
         r_owner     <= OwnerIF;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_len       <= 3'd0;
         r_wdata     <= 32'h0;
         r_k         <= 3'd0;
         r_if_data   <= 32'h0;
         r_mem_rdata <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_mem || w_grant_if) begin
            r_owner <= w_grant_mem ? OwnerMEM : OwnerIF;
            r_we    <= w_grant_mem && mem_we_i;
            r_addr  <= w_grant_mem ? mem_addr_i : if_addr_i;
            r_len   <= w_grant_mem ? len_bytes(mem_len_i) : 3'd4;
            r_wdata <= mem_wdata_i;
            r_k     <= 3'd0;
            // Unused upper lanes must read back as zero.
            if (w_grant_if) r_if_data <= 32'h0;
            if (w_grant_mem && !mem_we_i) r_mem_rdata <= 32'h0;
         end
         if (r_state == MemXfer) begin
            r_k <= r_k + 3'd1;
            if (!r_we && (r_k != 3'd0)) begin
               if (r_owner == OwnerIF) r_if_data[{w_lane, 3'b000} +: 8] <= ram_din_i;
               else r_mem_rdata[{w_lane, 3'b000} +: 8] <= ram_din_i;
            end
         end
      end
   end

   assign ram_addr_o  = w_ram_addr;
   assign ram_dout_o  = w_ram_dout;
   assign ram_wr_o    = w_ram_wr;
   assign if_done_o   = w_if_done;
   assign mem_done_o  = w_mem_done;
   assign if_data_o   = r_if_data;
   assign mem_rdata_o = r_mem_rdata;
   assign busy_o      = (r_state != MemIdle);

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : schedule-based reference model of the IF/MEM memory controller
// Revision    : 1.0
// ============================================================================
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, if_flush_i, if_done_o;
   logic [31:0] if_addr_i, if_data_o;
   logic        mem_req_i, mem_we_i, mem_done_o;
   logic [1:0]  mem_len_i;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic [31:0] ram_addr_o;
   logic [7:0]  ram_dout_o, ram_din_i;
   logic        ram_wr_o, busy_o;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
      .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
      .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
      .ram_din_i(ram_din_i), .busy_o(busy_o)
   );

   // env_ram is the physical RAM the DUT drives; ref_ram is the model's view.
   logic [7:0] env_ram [logic [31:0]];
   logic [7:0] ref_ram [logic [31:0]];

   function automatic logic [7:0] env_rd(input logic [31:0] a);
      return env_ram.exists(a) ? env_ram[a] : 8'h00;
   endfunction
   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
   endfunction

   always @(posedge clk) begin
      ram_din_i <= env_rd(ram_addr_o);
      if (ram_wr_o) env_ram[ram_addr_o] = ram_dout_o;
   end

   typedef struct {
      logic        busy;
      logic        wr;
      bit          chk_addr;
      logic [31:0] addr;
      bit          chk_dout;
      logic [7:0]  dout;
      logic        if_done;
      logic        mem_done;
      bit          chk_ifd;
      logic [31:0] ifd;
      bit          chk_md;
      logic [31:0] md;
   } exp_t;

   exp_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_if_data, last_md;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
      end
   endtask

   function automatic exp_t idle_rec();
      exp_t r;
      r.busy = 1'b0; r.wr = 1'b0; r.chk_addr = 1'b1; r.addr = 32'h0;
      r.chk_dout = 1'b0; r.dout = 8'h00; r.if_done = 1'b0; r.mem_done = 1'b0;
      r.chk_ifd = 1'b0; r.ifd = 32'h0; r.chk_md = 1'b0; r.md = 32'h0;
      return r;
   endfunction

   function automatic exp_t zero_rec();
      exp_t r;
      r = idle_rec();
      r.chk_dout = 1'b1; r.chk_ifd = 1'b1; r.chk_md = 1'b1;
      return r;
   endfunction

   always @(negedge clk) begin : compare
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("busy", {31'b0, busy_o}, {31'b0, e.busy});
         chk("ram_wr", {31'b0, ram_wr_o}, {31'b0, e.wr});
         chk("if_done", {31'b0, if_done_o}, {31'b0, e.if_done});
         chk("mem_done", {31'b0, mem_done_o}, {31'b0, e.mem_done});
         if (e.chk_addr) chk("ram_addr", ram_addr_o, e.addr);
         if (e.chk_dout) chk("ram_dout", {24'b0, ram_dout_o}, {24'b0, e.dout});
         if (e.chk_ifd)  chk("if_data", if_data_o, e.ifd);
         if (e.chk_md)   chk("mem_rdata", mem_rdata_o, e.md);
         if (if_done_o)  last_if_data = if_data_o;
         if (mem_done_o) last_md = mem_rdata_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(idle_rec());
         tick();
      end
   endtask

   // One request from cycle T (idle, request sampled) through the done cycle.
   task automatic txn(input bit is_if, input bit we, input logic [1:0] lc,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int flush_at, input bit flush_mem);
      int n, nrec;
      logic [31:0] val;
      exp_t r;
      n = is_if ? 4 : (lc == 2'b00 ? 1 : (lc == 2'b01 ? 2 : 4));
      val = 32'h0;
      if (is_if) begin
         if_req_i = 1'b1; if_addr_i = a;
      end else begin
         mem_req_i = 1'b1; mem_we_i = we; mem_len_i = lc;
         mem_addr_i = a; mem_wdata_i = wd;
         if (flush_mem) if_flush_i = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
         if (we) ref_ram[a + k] = wd[8*k +: 8];
         else val[8*k +: 8] = ref_rd(a + k);
      end
      exp_q.push_back(idle_rec());
      for (int k = 0; k < n; k++) begin
         r = idle_rec();
         r.busy = 1'b1; r.wr = we; r.addr = a + k;
         r.chk_dout = we; r.dout = wd[8*k +: 8];
         exp_q.push_back(r);
      end
      if (!we) begin
         r = idle_rec();
         r.busy = 1'b1; r.chk_addr = 1'b0;
         exp_q.push_back(r);
      end
      r = idle_rec();
      r.busy = 1'b1;
      r.if_done = is_if; r.mem_done = !is_if;
      r.chk_ifd = is_if; r.ifd = val;
      r.chk_md = !is_if && !we; r.md = val;
      exp_q.push_back(r);
      nrec = n + (we ? 2 : 3);
      if (is_if && flush_at > 0) begin
         // Flushed fetch: no done, idle on the following cycle.
         while (exp_q.size() > flush_at + 1) void'(exp_q.pop_back());
         r = exp_q.pop_back();
         r.if_done = 1'b0; r.chk_ifd = 1'b0;
         exp_q.push_back(r);
         nrec = flush_at + 1;
      end
      for (int i = 0; i < nrec; i++) begin
         if (is_if && flush_at > 0 && i == flush_at) if_flush_i = 1'b1;
         tick();
      end
      if (is_if) if_req_i = 1'b0; else mem_req_i = 1'b0;
      if_flush_i = 1'b0;
   endtask

   task automatic preset(input logic [31:0] a, input logic [7:0] b);
      env_ram[a] = b;
      ref_ram[a] = b;
   endtask

   initial begin
      logic [31:0] a, wd;
      logic [7:0]  old2, old3;
      int op, mism;
      rst = 1'b1;
      if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
      mem_req_i = 0; mem_we_i = 0; mem_len_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
      last_if_data = 32'hDEADBEEF; last_md = 32'hDEADBEEF;
      for (int i = 0; i < 32'h400; i++) preset(i, 8'($urandom));
      for (int i = 0; i < 16; i++) preset(32'hFFFFFFF0 + i, 8'($urandom));
      tick();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(zero_rec());
         tick();
      end
      rst = 1'b0;
      idle(2);

      // Word fetch with literal result.
      preset(32'h100, 8'h13); preset(32'h101, 8'h05);
      preset(32'h102, 8'h10); preset(32'h103, 8'h00);
      txn(1, 0, 2'b10, 32'h100, 0, 0, 0);
      chk("fetch_literal", last_if_data, 32'h00100513);

      // Simultaneous IF and MEM: MEM first, IF at the next idle.
      preset(32'h200, 8'hFF);
      if_req_i = 1'b1; if_addr_i = 32'h0;
      txn(0, 0, 2'b00, 32'h200, 0, 0, 0);
      chk("byte_load_literal", last_md, 32'h000000FF);
      txn(1, 0, 2'b10, 32'h0, 0, 0, 0);

      // Half store, neighbour byte untouched.
      preset(32'h13, 8'h5A);
      txn(0, 1, 2'b01, 32'h11, 32'hAABBCCDD, 0, 0);
      chk("half_store_b0", {24'b0, env_rd(32'h11)}, 32'hDD);
      chk("half_store_b1", {24'b0, env_rd(32'h12)}, 32'hCC);
      chk("half_store_keep", {24'b0, env_rd(32'h13)}, 32'h5A);

      // Flush mid-fetch, then a fresh fetch right away.
      txn(1, 0, 2'b10, 32'h40, 0, 3, 0);
      txn(1, 0, 2'b10, 32'h44, 0, 0, 0);

      // Word load across the top of the address space.
      preset(32'hFFFFFFFE, 8'h11); preset(32'hFFFFFFFF, 8'h22);
      preset(32'h0, 8'h33); preset(32'h1, 8'h44);
      txn(0, 0, 2'b10, 32'hFFFFFFFE, 0, 0, 0);
      chk("wrap_literal", last_md, 32'h44332211);

      // Reset two cycles into a word store.
      a = 32'h300;
      old2 = ref_rd(a + 2); old3 = ref_rd(a + 3);
      wd = ~{old3, old2, ref_rd(a + 1), ref_rd(a)};
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = a; mem_wdata_i = wd;
      exp_q.push_back(idle_rec());
      for (int k = 0; k < 2; k++) begin
         exp_t r;
         r = idle_rec();
         r.busy = 1'b1; r.wr = 1'b1; r.addr = a + k; r.chk_dout = 1'b1; r.dout = wd[8*k +: 8];
         exp_q.push_back(r);
         ref_ram[a + k] = wd[8*k +: 8];
      end
      exp_q.push_back(zero_rec());
      for (int i = 0; i < 4; i++) begin
         if (i == 2) rst = 1'b1;
         if (i == 3) begin rst = 1'b0; mem_req_i = 1'b0; end
         tick();
      end
      chk("rst_store_b0", {24'b0, env_rd(a)}, {24'b0, wd[7:0]});
      chk("rst_store_b1", {24'b0, env_rd(a + 1)}, {24'b0, wd[15:8]});
      chk("rst_store_b2", {24'b0, env_rd(a + 2)}, {24'b0, old2});
      chk("rst_store_b3", {24'b0, env_rd(a + 3)}, {24'b0, old3});

      // Flush held during a MEM word load has no effect.
      txn(0, 0, 2'b11, 32'h120, 0, 0, 1);

      // Randomised traffic.
      for (int t = 0; t < 250; t++) begin
         op = $urandom_range(0, 9);
         if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFF0 + $urandom_range(0, 15);
         else a = $urandom_range(0, 32'h3FC);
         if (op < 4)
            txn(1, 0, 2'b10, a, 0, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0, 0);
         else
            txn(0, op >= 7, 2'($urandom_range(0, 3)), a, $urandom,
                0, $urandom_range(0, 9) == 0);
         idle($urandom_range(0, 2));
      end

      mism = 0;
      for (int i = 0; i < 32'h400; i++) if (env_rd(i) !== ref_rd(i)) mism++;
      for (int i = 0; i < 16; i++)
         if (env_rd(32'hFFFFFFF0 + i) !== ref_rd(32'hFFFFFFF0 + i)) mism++;
      chk("ram_image", mism, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between instruction fetch (IF) and the MEM stage. Both requesters share one byte-wide RAM port. The block grants one requester at a time and sequences 1/2/4-byte little-endian transfers byte by byte. It returns an assembled word with a one-cycle done pulse, and the pipeline stalls on the pending requester until that pulse.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width for all address ports.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req_i` in 1: fetch request (always 4 bytes), held until `if_done_o`.
- `if_addr_i` in ADDR_WIDTH: fetch address.
- `if_flush_i` in 1: cancels the pending or in-progress fetch (branch taken).
- `if_done_o` out 1: one-cycle pulse; `if_data_o` valid.
- `if_data_o` out 32: fetched instruction.
- `mem_req_i` in 1: data request, held until `mem_done_o`.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_len_i` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_addr_i` in ADDR_WIDTH: data address.
- `mem_wdata_i` in 32: store data; byte k = [8k+7:8k].
- `mem_done_o` out 1: one-cycle pulse.
- `mem_rdata_o` out 32: load data, zero-extended (MEM stage sign-extends).
- `ram_addr_o` out ADDR_WIDTH: RAM byte address.
- `ram_dout_o` out 8: RAM write byte.
- `ram_wr_o` out 1: RAM write strobe.
- `ram_din_i` in 8: RAM read byte, valid one cycle after its address.
- `busy_o` out 1: high while state != IDLE.

## Operation
- States are IDLE, XFER and DONE.
- **IDLE**
  - Samples requests. `mem_req_i` has priority over `if_req_i` because it belongs to the older instruction.
  - `if_req_i` is ignored while `if_flush_i` is high.
  - On a grant, latch owner, we, address, length N (1/2/4) and wdata, clear the byte counter k, then go to XFER.
- **XFER**
  - Each cycle, drive `ram_addr_o` = latched addr + k, with the sum modulo 2^ADDR_WIDTH (wraps at the top of the address space).
  - Store: `ram_wr_o`=1 and `ram_dout_o` = byte k of wdata. After the cycle with k = N-1, go to DONE.
  - Load: `ram_wr_o`=0. Byte k is captured from `ram_din_i` in the cycle after its address into buffer lane k.
    - Address phase runs k = 0..N-1. One extra capture cycle follows for the last byte, then go to DONE.
  - Unused upper lanes read as 0.
- **DONE**
  - Assert the owner's done pulse with the registered data, then go to IDLE.
  - The requester drops or changes its request in the cycle after done. The requester is registered, so IDLE never re-serves a stale request.
- **Flush**
  - `if_flush_i` while the owner is IF, in XFER or DONE: abort. Go to IDLE next cycle and suppress `if_done_o`.
  - Safe because fetches never write.
  - MEM transfers are never aborted; flush has no effect on them.
- **Simultaneous requests:** MEM wins. IF waits and is served at the next IDLE. There is no starvation because MEM requests are one per instruction.
- **Reset values** (every output, and on reset mid-transfer):
  - State IDLE, all done pulses 0, `ram_wr_o`=0.
  - `ram_addr_o`, `ram_dout_o`, `if_data_o`, `mem_rdata_o` = 0; `busy_o`=0.
  - A partially completed store is not rolled back.
- **Outputs when not transferring:** `ram_wr_o`=0 in every state except store XFER, and `ram_addr_o` holds 0.

## Timing
- Request seen in IDLE at cycle T; first RAM address at T+1.
- Store of N bytes: writes in T+1..T+N, `mem_done_o` at T+N+1.
  - Word store latency is 5 cycles.
- Load of N bytes: addresses in T+1..T+N, data on `ram_din_i` in T+2..T+N+1, done at T+N+2.
  - Fetch and word load latency is 6 cycles; byte load is 3.
- Back-to-back: the next grant is no earlier than DONE+1 (IDLE), so the first address comes at DONE+2.
- Done data is registered and valid only in the done cycle. It is held afterwards but not guaranteed.

## Structure
- Add to Defines.vh:
  - length codes `MemByte`/`MemHalf`/`MemWord`;
  - state encodings `MemIdle`/`MemXfer`/`MemDone`;
  - owner codes `OwnerIF`/`OwnerMEM`.
- Single module, no sub-module; the byte-lane assembly is an indexed register write.
- The top level wires `mem_ctrl` between IF, MEM and the RAM, and ORs pending-not-done into the pipeline stall controller.

## Test plan
- **IF word fetch:** RAM[0x100..0x103] = 13 05 10 00, IF req at 0x100.
  - Required: addresses 0x100..0x103 in T+1..T+4.
  - Required: `if_done_o` at T+6 with `if_data_o`=0x00100513.
- **Simultaneous requests:** IF req at 0x0 and MEM byte load at 0x200 (RAM=0xFF) in the same cycle.
  - Required: MEM served first, `mem_rdata_o`=0x000000FF at T+3.
  - Required: IF address phase starts after the next IDLE.
- **Half store:** wdata 0xAABBCCDD at 0x11.
  - Required: `ram_wr_o`=1 only in T+1..T+2 with (0x11,0xDD),(0x12,0xCC).
  - Required: `mem_done_o` at T+3, RAM[0x13] unchanged.
- **Flush mid-fetch:** `if_flush_i` pulsed at T+3 of a fetch.
  - Required: no `if_done_o`, `busy_o`=0 at T+4.
  - Required: a new IF req at T+4 is granted normally.
- **Address wrap:** word load at 0xFFFFFFFE.
  - Required: addresses FFFFFFFE, FFFFFFFF, 0, 1.
  - Required: lanes assembled in that order.
- **Reset mid-store:** `rst` at T+2 of a word store.
  - Required: from the next cycle `ram_wr_o`=0, all outputs 0, state IDLE, no done.
  - Required: RAM bytes 0..1 are written and bytes 2..3 are not.
